// File: rtl/bus_arbiter_4.sv
// Round-robin arbiter sharing one 8-bit bus among four requesters, with bounded hold time.
// Registered one-hot grant and encoded select; bus_value is the 4:1 byte mux driven by sel.
module bus_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [7:0] in_a,
  input  logic [7:0] in_b,
  input  logic [7:0] in_c,
  input  logic [7:0] in_d,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic [7:0] bus_value,
  output logic       bus_valid
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  localparam logic [3:0] HoldLast = 4'(MAX_HOLD - 1);

  state_e     state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] last_q, last_d;
  logic [3:0] hold_q, hold_d;

  logic       own, others, take;
  logic [3:0] mask;
  logic [1:0] win;

  // First set bit of mask searching last+1, last+2, last+3, last (mod 4).
  function automatic logic [1:0] pick(input logic [3:0] m, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] w;
    logic       found;
    w     = last;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && m[idx]) begin
        w     = idx;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    last_d  = last_q;
    hold_d  = hold_q;
    take    = 1'b0;
    mask    = req;
    own     = |(req & grant_q);
    others  = |(req & ~grant_q);

    unique case (state_q)
      StIdle: begin
        if (|req) take = 1'b1;
      end
      StGrant: begin
        if (!own) begin
          if (others) begin
            take = 1'b1;
          end else begin
            state_d = StIdle;
            grant_d = 4'b0000;
          end
        end else if (others && hold_q == HoldLast) begin
          // Preemption: the current owner is excluded from this search.
          take = 1'b1;
          mask = req & ~grant_q;
        end else begin
          hold_d = (hold_q < HoldLast) ? hold_q + 4'd1 : hold_q;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = 4'b0000;
      end
    endcase

    win = pick(mask, last_q);
    if (take) begin
      state_d = StGrant;
      grant_d = 4'b0001 << win;
      sel_d   = win;
      last_d  = win;
      hold_d  = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      grant_q <= 4'b0000;
      sel_q   <= 2'd0;
      last_q  <= 2'd3;
      hold_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    bus_value = in_a;
    unique case (sel_q)
      2'd0: bus_value = in_a;
      2'd1: bus_value = in_b;
      2'd2: bus_value = in_c;
      2'd3: bus_value = in_d;
      default: bus_value = in_a;
    endcase
  end

  assign grant     = grant_q;
  assign sel       = sel_q;
  assign bus_valid = (state_q == StGrant);

endmodule

// File: tb/tb_bus_arbiter_4.sv
// Directed bench for bus_arbiter_4 (MAX_HOLD = 4): reset, single grant, rotation,
// lone owner, handover, preemption between two requesters and reset mid-grant.
module tb_bus_arbiter_4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [7:0] in_a, in_b, in_c, in_d;
  logic [3:0] grant;
  logic [1:0] sel;
  logic [7:0] bus_value;
  logic       bus_valid;

  int n_checks = 0;
  int n_fail   = 0;

  bus_arbiter_4 #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_c      (in_c),
    .in_d      (in_d),
    .grant     (grant),
    .sel       (sel),
    .bus_value (bus_value),
    .bus_valid (bus_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (grant !== 4'b0000 || sel !== 2'd0 || bus_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset cyc%0d: grant=%b sel=%0d valid=%b, want 0000/0/0",
                 i, grant, sel, bus_valid);
      end
    end
    reset = 1'b0;
    req   = 4'b0000;
    tick();
    n_checks++;
    if (grant !== 4'b0000 || bus_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: grant=%b valid=%b, want 0000/0", grant, bus_valid);
    end
  endtask

  task automatic test_single();
    in_c = 8'hE4;
    req  = 4'b0100;
    tick();
    n_checks++;
    if (grant !== 4'b0100 || sel !== 2'd2 || bus_value !== 8'hE4 || bus_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant: grant=%b sel=%0d bus=%h valid=%b, want 0100/2/e4/1",
               grant, sel, bus_value, bus_valid);
    end
    in_c = 8'h5A;
    #1;
    n_checks++;
    if (bus_value !== 8'h5A) begin
      n_fail++;
      $display("FAIL bus_comb: bus_value=%h, want 5a", bus_value);
    end
    req = 4'b0000;
    tick();
    n_checks++;
    if (grant !== 4'b0000 || bus_valid !== 1'b0 || sel !== 2'd2) begin
      n_fail++;
      $display("FAIL single_release: grant=%b valid=%b sel=%0d, want 0000/0/2",
               grant, bus_valid, sel);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    logic [1:0] exp_s;
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 17; i++) begin
      tick();
      exp_s = 2'((i / 4) % 4);
      exp_g = 4'b0001 << exp_s;
      n_checks++;
      if (grant !== exp_g || sel !== exp_s || bus_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL round_robin edge%0d: grant=%b sel=%0d valid=%b, want %b/%0d/1",
                 i + 1, grant, sel, bus_valid, exp_g, exp_s);
      end
    end
    n_checks++;
    if (bus_value !== in_a) begin
      n_fail++;
      $display("FAIL rr_bus: bus_value=%h, want %h", bus_value, in_a);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_two_way_preempt();
    logic [3:0] exp_g;
    do_reset();
    req = 4'b0101;
    for (int i = 0; i < 12; i++) begin
      tick();
      exp_g = ((i / 4) % 2 == 0) ? 4'b0001 : 4'b0100;
      n_checks++;
      if (grant !== exp_g) begin
        n_fail++;
        $display("FAIL two_way edge%0d: grant=%b, want %b", i + 1, grant, exp_g);
      end
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_lone_owner();
    int bad;
    bad = 0;
    req = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (grant !== 4'b0010 || bus_valid !== 1'b1 || sel !== 2'd1) begin
        n_fail++;
        $display("FAIL lone_owner cyc%0d: grant=%b valid=%b sel=%0d, want 0010/1/1",
                 i, grant, bus_valid, sel);
      end
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_d = 8'h3D;
    req  = 4'b0001;
    tick();
    n_checks++;
    if (grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL handover_setup: grant=%b, want 0001", grant);
    end
    req = 4'b1000;
    tick();
    n_checks++;
    if (grant !== 4'b1000 || bus_valid !== 1'b1 || sel !== 2'd3 || bus_value !== 8'h3D) begin
      n_fail++;
      $display("FAIL handover: grant=%b valid=%b sel=%0d bus=%h, want 1000/1/3/3d",
               grant, bus_valid, sel, bus_value);
    end
    req = 4'b0000;
    tick();
    n_checks++;
    if (grant !== 4'b0000 || bus_valid !== 1'b0 || sel !== 2'd3) begin
      n_fail++;
      $display("FAIL handover_idle: grant=%b valid=%b sel=%0d, want 0000/0/3",
               grant, bus_valid, sel);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 4'b0010;
    tick();
    n_checks++;
    if (grant !== 4'b0010) begin
      n_fail++;
      $display("FAIL midreset_setup: grant=%b, want 0010", grant);
    end
    req   = 4'b1111;
    reset = 1'b1;
    tick();
    n_checks++;
    if (grant !== 4'b0000 || bus_valid !== 1'b0 || sel !== 2'd0) begin
      n_fail++;
      $display("FAIL midreset: grant=%b valid=%b sel=%0d, want 0000/0/0",
               grant, bus_valid, sel);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (grant !== 4'b0001 || bus_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_restart: grant=%b valid=%b, want 0001/1", grant, bus_valid);
    end
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    in_a  = 8'hA1;
    in_b  = 8'hB2;
    in_c  = 8'hC3;
    in_d  = 8'hD4;
    test_reset();
    test_single();
    test_round_robin();
    test_two_way_preempt();
    test_lone_owner();
    test_back_to_back();
    test_reset_mid_grant();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
